// File: rtl/rr_arb_mux_if.sv
// Handshake bundle for rr_arb_mux: N request channels in, one registered channel out.
// The master side drives requests and consumer ready; the slave side is the arbiter.
interface rr_arb_mux_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4
);
  localparam int SELW = $clog2(N);

  logic               mode;
  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;
  logic               out_ready;

  modport master (
    output mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_arb_mux.sv
// N-channel arbitrating mux with a single registered output stage.
// Fixed-priority or round-robin grant selected at run time by mode.
module rr_arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input logic         clk,
  input logic         rst,
  rr_arb_mux_if.slave bus
);
  localparam int SELW = $clog2(N);
  localparam int unsigned NU = N;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_sel_q,   out_sel_d;
  logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;

  logic [N-1:0]     grant;
  logic [SELW-1:0]  grant_idx;
  logic             grant_any;
  logic             can_load;
  logic             xfer;
  int unsigned      start;
  int unsigned      idx;

  // Rotating search from start; fixed priority is simply a search from zero.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    start     = bus.mode ? 32'(rr_ptr_q) : 32'd0;
    idx       = 0;
    for (int unsigned k = 0; k < NU; k++) begin
      idx = start + k;
      if (idx >= NU) idx = idx - NU;
      if (!grant_any && bus.in_valid[idx]) begin
        grant_any      = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = SELW'(idx);
      end
    end
  end

  assign can_load = ~out_valid_q | bus.out_ready;
  assign xfer     = grant_any & can_load;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data[int'(grant_idx)*WIDTH +: WIDTH];
      out_sel_d   = grant_idx;
      rr_ptr_d    = (grant_idx == SELW'(N-1)) ? '0 : grant_idx + 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.in_ready  = grant & {N{can_load}};
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: directed scenarios with literal expectations plus a random
// phase, all checked every cycle against a queue-free behavioural model of the arbiter.
module tb_rr_arb_mux;
  localparam int W = 32;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  logic rst3;
  always #5 clk = ~clk;

  rr_arb_mux_if #(.WIDTH(W), .N(N)) bus ();
  rr_arb_mux_if #(.WIDTH(8), .N(3)) bus3 ();

  rr_arb_mux #(.WIDTH(W), .N(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  rr_arb_mux #(.WIDTH(8), .N(3)) dut3 (.clk(clk), .rst(rst3), .bus(bus3));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: what the output register and pointer must hold
  logic          m_init = 1'b0;
  logic          m_valid;
  logic [W-1:0]  m_data;
  int            m_sel;
  int            m_ptr;
  logic          nxt_valid;
  logic [W-1:0]  nxt_data;
  int            nxt_sel;
  int            nxt_ptr;

  function automatic int model_grant(input logic md, input logic [N-1:0] v, input int ptr);
    int s;
    s = md ? ptr : 0;
    for (int k = 0; k < N; k++)
      if (v[(s + k) % N]) return (s + k) % N;
    return -1;
  endfunction

  // Compare process: mid-cycle, inputs are stable for the coming edge
  always @(negedge clk) begin
    int g;
    logic can;
    logic [N-1:0] exp_ready;
    can = !m_valid || bus.out_ready;
    g   = model_grant(bus.mode, bus.in_valid, m_ptr);
    exp_ready = (g >= 0 && can) ? N'(1 << g) : '0;
    nxt_valid = m_valid; nxt_data = m_data; nxt_sel = m_sel; nxt_ptr = m_ptr;
    if (g >= 0 && can) begin
      nxt_valid = 1'b1;
      nxt_data  = bus.in_data[g*W +: W];
      nxt_sel   = g;
      nxt_ptr   = (g + 1) % N;
    end else if (m_valid && bus.out_ready) begin
      nxt_valid = 1'b0;
    end
    if (m_init) begin
      chk("model_in_ready", 32'(bus.in_ready), 32'(exp_ready));
      chk("model_out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("model_out_data", bus.out_data, m_data);
      chk("model_out_sel", 32'(bus.out_sel), 32'(m_sel));
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_init  <= 1'b1;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sel   <= 0;
      m_ptr   <= 0;
    end else if (m_init) begin
      m_valid <= nxt_valid;
      m_data  <= nxt_data;
      m_sel   <= nxt_sel;
      m_ptr   <= nxt_ptr;
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic md, input logic [N-1:0] v, input logic rdy);
    bus.mode      = md;
    bus.in_valid  = v;
    bus.out_ready = rdy;
  endtask

  task automatic set_data(input int ch, input logic [W-1:0] d);
    bus.in_data[ch*W +: W] = d;
  endtask

  int seq4 [6] = '{0, 1, 2, 3, 0, 1};
  int seq3 [6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    rst = 1'b1;
    rst3 = 1'b1;
    bus.in_data = '0;
    drive(1'b0, '0, 1'b0);
    bus3.mode = 1'b0; bus3.in_valid = '0; bus3.in_data = '0; bus3.out_ready = 1'b0;

    // Reset then idle
    cyc; cyc;
    rst = 1'b0;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_out_data", bus.out_data, 32'd0);
    chk("reset_out_sel", 32'(bus.out_sel), 32'd0);
    @(negedge clk);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd0);

    // Fixed priority: ch1 beats ch3 every cycle
    cyc;
    set_data(1, 32'h1111_1111);
    set_data(3, 32'h3333_3333);
    drive(1'b0, 4'b1010, 1'b1);
    @(negedge clk);
    chk("fp_in_ready", 32'(bus.in_ready), 32'b0010);
    for (int i = 0; i < 3; i++) begin
      cyc;
      chk("fp_out_data", bus.out_data, 32'h1111_1111);
      chk("fp_out_sel", 32'(bus.out_sel), 32'd1);
      chk("fp_out_valid", 32'(bus.out_valid), 32'd1);
    end

    // Round-robin fairness from a fresh pointer
    rst = 1'b1; drive(1'b0, '0, 1'b1);
    cyc;
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_data(i, 32'(32'hA0 + i));
    drive(1'b1, 4'b1111, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc;
      chk("rr_out_sel", 32'(bus.out_sel), 32'(seq4[i]));
      chk("rr_out_valid", 32'(bus.out_valid), 32'd1);
    end

    // Stall and hold: pointer now at 2, so ch2 loads next
    set_data(2, 32'hDEAD_BEEF);
    cyc;
    chk("stall_load_sel", 32'(bus.out_sel), 32'd2);
    drive(1'b1, 4'b1111, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      cyc;
      chk("stall_out_data", bus.out_data, 32'hDEAD_BEEF);
      chk("stall_out_sel", 32'(bus.out_sel), 32'd2);
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
    end
    drive(1'b1, 4'b1111, 1'b1);
    @(negedge clk);
    chk("unstall_in_ready", 32'(bus.in_ready), 32'b1000);
    cyc;
    chk("unstall_out_sel", 32'(bus.out_sel), 32'd3);

    // Drain bubble after a single transfer
    set_data(0, 32'h5);
    drive(1'b0, 4'b0001, 1'b1);
    cyc;
    chk("drain_valid1", 32'(bus.out_valid), 32'd1);
    chk("drain_data1", bus.out_data, 32'h5);
    drive(1'b0, 4'b0000, 1'b1);
    cyc;
    chk("drain_valid0", 32'(bus.out_valid), 32'd0);
    chk("drain_data_hold", bus.out_data, 32'h5);
    chk("drain_sel_hold", 32'(bus.out_sel), 32'd0);

    // Reset mid-stall discards the output and rewinds the pointer
    drive(1'b1, 4'b0100, 1'b1);
    cyc;
    drive(1'b1, 4'b1111, 1'b0);
    cyc;
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    cyc;
    rst = 1'b0;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_data", bus.out_data, 32'd0);
    drive(1'b1, 4'b1111, 1'b1);
    @(negedge clk);
    chk("midrst_ptr_grant", 32'(bus.in_ready), 32'b0001);

    // Random phase against the model
    for (int i = 0; i < 400; i++) begin
      cyc;
      rst = ($urandom_range(0, 39) == 0);
      for (int c = 0; c < N; c++) set_data(c, $urandom);
      drive(1'($urandom), N'($urandom), ($urandom_range(0, 3) != 0));
    end
    cyc;
    rst = 1'b0;

    // Non-power-of-two instance: round-robin wraps at 2
    rst3 = 1'b0;
    bus3.mode = 1'b1; bus3.in_valid = 3'b111; bus3.out_ready = 1'b1;
    bus3.in_data = 24'h332211;
    for (int i = 0; i < 6; i++) begin
      cyc;
      chk("n3_out_sel", 32'(bus3.out_sel), 32'(seq3[i]));
      chk("n3_out_data", 32'(bus3.out_data), 32'(8'h11 * (seq3[i] + 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-channel, WIDTH-bit arbitrating multiplexer with valid/ready handshakes and a registered output stage.
- Successor to the fixed 4:1 combinational selector. The select comes from an internal arbiter, not an external selector.
- Arbitration mode is fixed-priority or round-robin, chosen at run time.
- Sits between multiple requesters (e.g. IF and MEM access paths) and a single shared consumer (memory port or writeback bus).

Parameters:
- WIDTH, 32, data width per channel.
- N, 4, number of input channels (2..16).
- SELW, $clog2(N), width of channel index; derived localparam, not overridable.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = fixed priority (lowest index wins), 1 = round-robin.
- in_valid  input  N  per-channel request valid.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N  per-channel accept; combinational.
- out_valid  output  1  output register holds valid data.
- out_data  output  WIDTH  registered selected data.
- out_sel  output  SELW  index of channel that supplied out_data.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (rst=1 at posedge): out_valid=0, out_data=0, out_sel=0, rr_ptr=0. Reset overrides any handshake in the same cycle.
- can_load = ~out_valid | out_ready. This gives full throughput with one transfer per cycle.
- Grant (combinational, one-hot or zero):
  - mode=0: lowest index i with in_valid[i]=1.
  - mode=1: first i with in_valid[i]=1 searching rr_ptr, rr_ptr+1, ... N-1, 0, ... rr_ptr-1 (wrap-around).
  - No valid input: grant=0.
- in_ready[i] = grant[i] & can_load. At most one in_ready high per cycle. in_ready never depends on in_ready itself (no loops).
- Input transfer on channel g when in_valid[g] & in_ready[g]. At the next edge:
  - out_data <= in_data[g]
  - out_sel <= g
  - out_valid <= 1
  - rr_ptr <= (g==N-1) ? 0 : g+1, in both modes.
- Latency: input handshake at cycle t gives out_valid=1 with that data at cycle t+1.
- Output transfer and no input transfer in the same cycle: out_valid <= 0, out_data and out_sel hold their last values.
- Output transfer and input transfer in the same cycle: the register reloads with the new data. out_valid stays 1 with no bubble.
- Stall (out_valid=1, out_ready=0):
  - out_data, out_sel and out_valid are held stable.
  - All in_ready=0. No input is consumed or dropped.
- rr_ptr changes only on an input transfer. A mode change takes effect for the grant in the same cycle and never resets rr_ptr.
- Requesters may drop in_valid without a transfer. The grant simply re-evaluates; no state is affected.
- N not a power of two: out_sel never exceeds N-1 and rr_ptr wraps at N-1.
- rst asserted mid-stall: the output is discarded and out_valid=0 on the next cycle.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, all in_valid=0 -> out_valid=0, out_data=0, out_sel=0, in_ready=0000.
- Fixed priority: mode=0, in_valid=1010, data ch1=0x11111111, ch3=0x33333333, out_ready=1 -> in_ready=0010. Next cycle out_data=0x11111111, out_sel=1. Repeats ch1 every cycle while held.
- Round-robin fairness: mode=1, in_valid=1111 held, out_ready=1, data ch_i=0xA0+i -> out_sel sequence 0,1,2,3,0,1 on consecutive cycles, out_valid=1 continuously.
- Stall and hold: load ch2=0xDEADBEEF, then out_ready=0 for 3 cycles with in_valid=1111 -> out_data=0xDEADBEEF, out_sel=2 held and in_ready=0000 throughout. After out_ready=1, the next grant is ch3.
- Drain bubble: single transfer ch0=0x5, then in_valid=0, out_ready=1 -> out_valid goes 1 then 0, out_data stays 0x5.
- Reset mid-stall plus N=3 instance: out_valid=1, out_ready=0, assert rst -> out_valid=0 the next cycle and rr_ptr=0. With N=3 in round-robin and all valid, out_sel cycles 0,1,2,0 and never reaches 3.
